// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pkg: shared types and constants for mem_port_arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  localparam int REQ_IF  = 0;
  localparam int REQ_LS  = 1;
  localparam int REQ_DBG = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_LS   = 2'b10,
    OWN_DBG  = 2'b11
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter_if: requester and memory-side signals of mem_port_arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_starve_cnt: saturating count of consecutive denied cycles; promotes at limit.  Rev 1.0
// ---------------------------------------------------------------------------
module arb_starve_cnt (
  input  logic       clk1,
  input  logic       reset,
  input  logic       req_i,
  input  logic       gnt_i,
  input  logic [3:0] limit_i,
  output logic       promote_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) begin
      cnt_d = 4'd0;
    end else if (cnt_q < limit_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign promote_o = (cnt_q == limit_i);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter: LS > IF > DBG arbiter for a single-ported memory, with starvation
// promotion of IF/DBG. Define ARB_PERF_CNT_EN for grant/stall counters.  Rev 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_gnt_if,
  output logic [31:0]       perf_gnt_ls,
  output logic [31:0]       perf_gnt_dbg,
  output logic [31:0]       perf_stall_if
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

  logic [2:0]        gnt_w;
  logic              if_promote_w;
  logic              dbg_promote_w;
  logic              mem_we_w;
  logic [ADDR_W-1:0] mem_addr_w;
  logic [DATA_W-1:0] mem_wdata_w;
  owner_e            owner_d;
  owner_e            owner_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  arb_starve_cnt u_if_starve (
    .clk1      (clk1),
    .reset     (reset),
    .req_i     (bus.if_req),
    .gnt_i     (gnt_w[REQ_IF]),
    .limit_i   (LIMIT),
    .promote_o (if_promote_w)
  );

  arb_starve_cnt u_dbg_starve (
    .clk1      (clk1),
    .reset     (reset),
    .req_i     (bus.dbg_req),
    .gnt_i     (gnt_w[REQ_DBG]),
    .limit_i   (LIMIT),
    .promote_o (dbg_promote_w)
  );

  // Promotions first (IF before DBG), then fixed priority.
  always_comb begin
    gnt_w = 3'b000;
    if (reset) begin
      if (if_promote_w && bus.if_req)        gnt_w[REQ_IF]  = 1'b1;
      else if (dbg_promote_w && bus.dbg_req) gnt_w[REQ_DBG] = 1'b1;
      else if (bus.ls_req)                   gnt_w[REQ_LS]  = 1'b1;
      else if (bus.if_req)                   gnt_w[REQ_IF]  = 1'b1;
      else if (bus.dbg_req)                  gnt_w[REQ_DBG] = 1'b1;
    end
  end

  always_comb begin
    mem_we_w    = 1'b0;
    mem_addr_w  = '0;
    mem_wdata_w = '0;
    owner_d     = OWN_NONE;
    if (gnt_w[REQ_LS]) begin
      mem_we_w    = bus.ls_we;
      mem_addr_w  = bus.ls_addr;
      mem_wdata_w = bus.ls_wdata;
      owner_d     = bus.ls_we ? OWN_NONE : OWN_LS;
    end else if (gnt_w[REQ_IF]) begin
      mem_addr_w  = bus.if_addr;
      owner_d     = OWN_IF;
    end else if (gnt_w[REQ_DBG]) begin
      mem_we_w    = bus.dbg_we;
      mem_addr_w  = bus.dbg_addr;
      mem_wdata_w = bus.dbg_wdata;
      owner_d     = bus.dbg_we ? OWN_NONE : OWN_DBG;
    end
  end

  assign bus.if_gnt    = gnt_w[REQ_IF];
  assign bus.ls_gnt    = gnt_w[REQ_LS];
  assign bus.dbg_gnt   = gnt_w[REQ_DBG];
  assign bus.mem_en    = |gnt_w;
  assign bus.mem_we    = mem_we_w;
  assign bus.mem_addr  = mem_addr_w;
  assign bus.mem_wdata = mem_wdata_w;

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      owner_q     <= OWN_NONE;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      if (owner_q == OWN_IF)  if_rdata_q  <= bus.mem_rdata;
      if (owner_q == OWN_LS)  ls_rdata_q  <= bus.mem_rdata;
      if (owner_q == OWN_DBG) dbg_rdata_q <= bus.mem_rdata;
    end
  end

  // Memory data only exists in the return cycle, so rdata bypasses it then and
  // the hold register keeps it visible afterwards.
  assign bus.if_rvalid  = (owner_q == OWN_IF);
  assign bus.ls_rvalid  = (owner_q == OWN_LS);
  assign bus.dbg_rvalid = (owner_q == OWN_DBG);
  assign bus.if_rdata   = bus.if_rvalid  ? bus.mem_rdata : if_rdata_q;
  assign bus.ls_rdata   = bus.ls_rvalid  ? bus.mem_rdata : ls_rdata_q;
  assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : dbg_rdata_q;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      perf_gnt_if   <= 32'd0;
      perf_gnt_ls   <= 32'd0;
      perf_gnt_dbg  <= 32'd0;
      perf_stall_if <= 32'd0;
    end else begin
      perf_gnt_if   <= perf_gnt_if   + 32'(gnt_w[REQ_IF]);
      perf_gnt_ls   <= perf_gnt_ls   + 32'(gnt_w[REQ_LS]);
      perf_gnt_dbg  <= perf_gnt_dbg  + 32'(gnt_w[REQ_DBG]);
      perf_stall_if <= perf_stall_if + 32'(bus.if_req && !gnt_w[REQ_IF]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the processor's single-ported unified 256x32 memory between three requesters: instruction fetch (IF), load/store (LS, MEM stage) and a debug/loader port (DBG).
- Sits between the pipeline stages and the memory array: one access per cycle, read data returned one cycle later with a valid pulse to the owning requester.
- Priority is LS > IF > DBG, with starvation counters that protect IF and DBG.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive denied cycles after which IF or DBG is promoted; legal range 1..15.

Ports:
- clk1  input  1  single clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request, read only.
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  fetch accepted this cycle.
- if_rvalid  output  1  fetch data valid.
- if_rdata  output  DATA_W  fetch data.
- ls_req  input  1  load/store request.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  ADDR_W  load/store address.
- ls_wdata  input  DATA_W  store data.
- ls_gnt  output  1  load/store accepted.
- ls_rvalid  output  1  load data valid; loads only.
- ls_rdata  output  DATA_W  load data.
- dbg_req  input  1  debug request.
- dbg_we  input  1  debug write enable.
- dbg_addr  input  ADDR_W  debug address.
- dbg_wdata  input  DATA_W  debug write data.
- dbg_gnt  output  1  debug accepted.
- dbg_rvalid  output  1  debug read data valid.
- dbg_rdata  output  DATA_W  debug read data.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid the cycle after a read with mem_en=1.

Behaviour:
- Reset values:
  - Registered outputs are 0: all *_rvalid and *_rdata.
  - Internal state is 0: owner register, both starve counters, and the perf counters when compiled in.
  - Combinational outputs (*_gnt, mem_*) are 0 while reset is low, regardless of requests.
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - gnt is combinational and issued in the same cycle as the request.
  - Exactly one gnt per cycle, and only when that requester's req=1.
- Arbitration order each cycle:
  1. If if_starve == STARVE_MAX and if_req: IF wins.
  2. Else if dbg_starve == STARVE_MAX and dbg_req: DBG wins.
  3. Else LS > IF > DBG.
  - If both promotions are pending, IF is served first; DBG is served next cycle.
- Starve counters:
  - 4-bit counter per requester, IF and DBG only.
  - Increments when req=1 and gnt=0; saturates at STARVE_MAX.
  - Clears on grant, or when req=0.
- Memory side:
  - mem_en=1 whenever any gnt=1.
  - mem_addr, mem_we and mem_wdata are muxed from the winner; IF always drives mem_we=0.
- Read return:
  - A 2-bit owner register (NONE/IF/LS/DBG) is captured when a read is granted.
  - Next cycle, the owner's rvalid pulses high for exactly one cycle and its rdata takes mem_rdata.
  - Writes set owner NONE and produce no rvalid.
- rdata holds its last value until the next rvalid for that port.
- Back-to-back reads from different ports are legal at full throughput: one grant and one rvalid per cycle.
- Reset asserted mid-access: the pending rvalid is dropped, and no read data is returned after reset deasserts.
- Address wrap: addresses are ADDR_W bits; no bounds checking is performed.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined:
  - Adds 32-bit wrapping counters perf_gnt_if, perf_gnt_ls, perf_gnt_dbg (grants) and perf_stall_if (cycles with if_req=1 and if_gnt=0).
  - Exposed as output ports of the same names; all reset to 0.
- When undefined: the ports and counters do not exist, and arbitration behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg:
  - owner encoding: OWN_NONE=2'b00, OWN_IF=2'b01, OWN_LS=2'b10, OWN_DBG=2'b11.
  - requester index constants.
  - default ADDR_W and DATA_W.
- One sub-module, arb_starve_cnt: the saturating per-requester starvation counter (inputs req, gnt, limit; output promote).
- The priority mux and owner register stay in the top module.

Test Plan:
- Single read:
  - Stimulus: ls_req=1, ls_we=0, ls_addr=8'h10 for one cycle, memory preloaded with 32'hDEADBEEF.
  - Required: ls_gnt=1 in the same cycle; ls_rvalid=1 and ls_rdata=32'hDEADBEEF exactly 1 cycle later.
- Conflict:
  - Stimulus: if_req=1 and ls_req=1 in the same cycle.
  - Required: ls_gnt=1, if_gnt=0.
  - Next cycle, with ls_req=0: if_gnt=1, then if_rvalid one cycle after that.
- IF starvation (STARVE_MAX=4):
  - Stimulus: ls_req held at 1 and if_req held at 1.
  - Required: ls granted in cycles 0-3; if_gnt=1 in cycle 4; ls granted again in cycle 5.
- DBG write then read:
  - Stimulus: dbg write of 32'h0000_00A5 to 8'hFF, then dbg read of 8'hFF.
  - Required: the write gives no dbg_rvalid; the read returns 32'h0000_00A5.
- Mid-access reset:
  - Stimulus: reset driven low in the cycle after an LS read grant.
  - Required: no ls_rvalid pulse; all outputs 0 while reset is low.
- Back-to-back reads:
  - Stimulus: LS read of 8'h01, then IF read of 8'h02, on consecutive cycles.
  - Required: rvalid goes to LS then IF on consecutive cycles, each with the correct data.
  - With ARB_PERF_CNT_EN defined: perf_gnt_ls=1 and perf_gnt_if=1.
